// File: rtl/mem_ctrl_pkg.sv
// Shared widths, state/owner encodings and ls_len codes for the memory controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_ctrl_pkg;

  localparam int ADDR_LEN = 32;
  localparam int REG_LEN  = 32;
  localparam int BYTE_W   = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_t;

  localparam logic [1:0] LEN_BYTE = 2'b00;
  localparam logic [1:0] LEN_HALF = 2'b01;
  localparam logic [1:0] LEN_WORD = 2'b10;

  // Byte count for an ls_len code; 10 and 11 both mean a full word.
  function automatic logic [2:0] len_bytes(input logic [1:0] len);
    case (len)
      LEN_BYTE: return 3'd1;
      LEN_HALF: return 3'd2;
      default:  return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Bundles the IF, MEM and RAM-side signals of the memory controller.
// Latency: n/a (wiring only).
// Backpressure: requesters hold req and fields until the matching done pulse.
// Ports: master = pipeline/RAM environment, slave = mem_ctrl.
// Option: MEM_CTRL_IF_ABORT_EN adds the if_abort signal.
interface mem_ctrl_if;
  import mem_ctrl_pkg::*;

  logic                if_req;
  logic [ADDR_LEN-1:0] if_addr;
  logic [REG_LEN-1:0]  if_data;
  logic                if_done;
`ifdef MEM_CTRL_IF_ABORT_EN
  logic                if_abort;
`endif
  logic                ls_req;
  logic                ls_wr;
  logic [1:0]          ls_len;
  logic                ls_signed;
  logic [ADDR_LEN-1:0] ls_addr;
  logic [REG_LEN-1:0]  ls_wdata;
  logic [REG_LEN-1:0]  ls_rdata;
  logic                ls_done;
  logic [ADDR_LEN-1:0] ram_a;
  logic                ram_wr;
  logic [BYTE_W-1:0]   ram_dout;
  logic [BYTE_W-1:0]   ram_din;

  modport master (
`ifdef MEM_CTRL_IF_ABORT_EN
    output if_abort,
`endif
    output if_req, if_addr, ls_req, ls_wr, ls_len, ls_signed, ls_addr, ls_wdata, ram_din,
    input  if_data, if_done, ls_rdata, ls_done, ram_a, ram_wr, ram_dout
  );

  modport slave (
`ifdef MEM_CTRL_IF_ABORT_EN
    input  if_abort,
`endif
    input  if_req, if_addr, ls_req, ls_wr, ls_len, ls_signed, ls_addr, ls_wdata, ram_din,
    output if_data, if_done, ls_rdata, ls_done, ram_a, ram_wr, ram_dout
  );

endinterface

// File: rtl/mem_extend.sv
// Sign/zero extends 1, 2 or 4 assembled little-endian bytes to a 32-bit value.
// Latency: combinational.
// Backpressure: none.
// Ports: raw (assembled bytes), len (ls_len code), sgn (sign-extend), ext (result).
module mem_extend
  import mem_ctrl_pkg::*;
(
  input  logic [REG_LEN-1:0] raw,
  input  logic [1:0]         len,
  input  logic               sgn,
  output logic [REG_LEN-1:0] ext
);

  always_comb begin
    ext = raw;
    case (len)
      LEN_BYTE: ext = {{(REG_LEN-BYTE_W){sgn & raw[BYTE_W-1]}}, raw[BYTE_W-1:0]};
      LEN_HALF: ext = {{(REG_LEN-2*BYTE_W){sgn & raw[2*BYTE_W-1]}}, raw[2*BYTE_W-1:0]};
      default:  ext = raw;
    endcase
  end

endmodule

// File: rtl/mem_ctrl.sv
// Arbitrates the byte-wide RAM port between IF word fetches and MEM loads/stores (MEM has priority).
// Latency: N-byte read done visible after accept+N+1 edges; N-byte write done after accept+N edges.
// Backpressure: one transaction at a time, req held until done; rdy low freezes all state.
// Ports: clk, rst_n (async active-low), rdy (global freeze), bus (mem_ctrl_if.slave).
// Option: MEM_CTRL_IF_ABORT_EN enables if_abort to cancel an in-flight IF read.
module mem_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rdy,
  mem_ctrl_if.slave  bus
);

  state_t              state_q, state_d;
  owner_t              owner_q, owner_d;
  logic [1:0]          len_q, len_d;
  logic                sgn_q, sgn_d;
  logic [REG_LEN-1:0]  wdata_q, wdata_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [REG_LEN-1:0]  rbuf_q, rbuf_d;
  logic [ADDR_LEN-1:0] ram_a_q, ram_a_d;
  logic                ram_wr_q, ram_wr_d;
  logic [BYTE_W-1:0]   ram_dout_q, ram_dout_d;
  logic [REG_LEN-1:0]  if_data_q, if_data_d;
  logic [REG_LEN-1:0]  ls_rdata_q, ls_rdata_d;
  logic                if_done_q, if_done_d;
  logic                ls_done_q, ls_done_d;

  logic                if_abort_w;
  logic [2:0]          nbytes;
  logic [2:0]          cnt_n;
  logic [1:0]          lane;
  logic [REG_LEN-1:0]  rbuf_cap;
  logic [REG_LEN-1:0]  ext_data;

`ifdef MEM_CTRL_IF_ABORT_EN
  assign if_abort_w = bus.if_abort;
`else
  assign if_abort_w = 1'b0;
`endif

  assign nbytes = len_bytes(len_q);
  assign cnt_n  = cnt_q + 3'd1;
  // The byte arriving now was addressed one RD edge earlier, so it lands in lane cnt-1.
  assign lane   = cnt_q[1:0] - 2'd1;

  always_comb begin
    rbuf_cap = rbuf_q;
    rbuf_cap[{lane, 3'b000} +: BYTE_W] = bus.ram_din;
  end

  // Extension sees the final byte as it is captured so done and data leave together.
  mem_extend u_extend (
    .raw (rbuf_cap),
    .len (len_q),
    .sgn (sgn_q),
    .ext (ext_data)
  );

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    len_d      = len_q;
    sgn_d      = sgn_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    rbuf_d     = rbuf_q;
    ram_a_d    = ram_a_q;
    ram_wr_d   = 1'b0;
    ram_dout_d = ram_dout_q;
    if_data_d  = if_data_q;
    ls_rdata_d = ls_rdata_q;
    if_done_d  = 1'b0;
    ls_done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.ls_req) begin
          owner_d = OWN_LS;
          len_d   = bus.ls_len;
          sgn_d   = bus.ls_signed;
          wdata_d = bus.ls_wdata;
          ram_a_d = bus.ls_addr;
          cnt_d   = 3'd0;
          rbuf_d  = '0;
          if (bus.ls_wr) begin
            state_d    = ST_WR;
            ram_wr_d   = 1'b1;
            ram_dout_d = bus.ls_wdata[BYTE_W-1:0];
          end else begin
            state_d = ST_RD;
          end
        end else if (bus.if_req && !if_abort_w) begin
          owner_d = OWN_IF;
          len_d   = LEN_WORD;
          sgn_d   = 1'b0;
          ram_a_d = bus.if_addr;
          cnt_d   = 3'd0;
          rbuf_d  = '0;
          state_d = ST_RD;
        end
      end

      ST_RD: begin
        if (owner_q == OWN_IF && if_abort_w) begin
          state_d = ST_IDLE;
        end else begin
          // cnt counts RD edges taken; edge c captures byte c-1 and presents byte c.
          cnt_d = cnt_n;
          if (cnt_q != 3'd0) rbuf_d = rbuf_cap;
          if (cnt_q < nbytes - 3'd1) ram_a_d = ram_a_q + 32'd1;
          if (cnt_q == nbytes) begin
            state_d = ST_DONE;
            if (owner_q == OWN_IF) begin
              if_data_d = ext_data;
              if_done_d = 1'b1;
            end else begin
              ls_rdata_d = ext_data;
              ls_done_d  = 1'b1;
            end
          end
        end
      end

      ST_WR: begin
        if (cnt_q == nbytes - 3'd1) begin
          state_d   = ST_DONE;
          ls_done_d = 1'b1;
        end else begin
          ram_wr_d   = 1'b1;
          ram_a_d    = ram_a_q + 32'd1;
          ram_dout_d = wdata_q[{cnt_n[1:0], 3'b000} +: BYTE_W];
          cnt_d      = cnt_n;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else if (rdy) begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q    <= OWN_IF;
      len_q      <= LEN_BYTE;
      sgn_q      <= 1'b0;
      wdata_q    <= '0;
      cnt_q      <= 3'd0;
      rbuf_q     <= '0;
      ram_a_q    <= '0;
      ram_wr_q   <= 1'b0;
      ram_dout_q <= '0;
      if_data_q  <= '0;
      ls_rdata_q <= '0;
      if_done_q  <= 1'b0;
      ls_done_q  <= 1'b0;
    end else if (rdy) begin
      owner_q    <= owner_d;
      len_q      <= len_d;
      sgn_q      <= sgn_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      rbuf_q     <= rbuf_d;
      ram_a_q    <= ram_a_d;
      ram_wr_q   <= ram_wr_d;
      ram_dout_q <= ram_dout_d;
      if_data_q  <= if_data_d;
      ls_rdata_q <= ls_rdata_d;
      if_done_q  <= if_done_d;
      ls_done_q  <= ls_done_d;
    end
  end

  assign bus.ram_a    = ram_a_q;
  assign bus.ram_wr   = ram_wr_q;
  assign bus.ram_dout = ram_dout_q;
  assign bus.if_data  = if_data_q;
  assign bus.ls_rdata = ls_rdata_q;
  assign bus.if_done  = if_done_q;
  assign bus.ls_done  = ls_done_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a synchronous byte RAM model frozen by rdy.
// Latency: n/a.
// Backpressure: n/a.
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic rdy;
  always #5 clk = ~clk;

  mem_ctrl_if bus();

  mem_ctrl u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rdy   (rdy),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // RAM model: address sampled on an edge, data out the following cycle.
  logic [7:0]  mem [0:65535];
  logic        pl_en;
  logic [15:0] pl_a;
  logic [7:0]  pl_d;

  always @(posedge clk) begin
    if (pl_en) begin
      mem[pl_a] <= pl_d;
    end else if (rdy) begin
      if (bus.ram_wr) mem[bus.ram_a[15:0]] <= bus.ram_dout;
      bus.ram_din <= mem[bus.ram_a[15:0]];
    end
  end

  task automatic preload(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    pl_en = 1'b1;
    pl_a  = a;
    pl_d  = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Issues one MEM load; lat is the sample index (0 = right after accept) where ls_done is seen.
  task automatic do_load(input logic [31:0] a, input logic [1:0] len, input logic sgn,
                         output logic [31:0] data, output int lat);
    @(negedge clk);
    bus.ls_req    = 1'b1;
    bus.ls_wr     = 1'b0;
    bus.ls_len    = len;
    bus.ls_signed = sgn;
    bus.ls_addr   = a;
    lat  = -1;
    data = 32'hx;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.ls_done === 1'b1 && lat < 0) begin
        lat  = i;
        data = bus.ls_rdata;
        bus.ls_req = 1'b0;
      end
    end
    bus.ls_req = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.ram_a, bus.ram_wr, bus.ram_dout, bus.if_data, bus.ls_rdata, bus.if_done, bus.ls_done} !== '0) begin
      errors++;
      $display("FAIL reset_hold got a=%h wr=%b do=%h if=%h ls=%h ifd=%b lsd=%b exp all zero",
               bus.ram_a, bus.ram_wr, bus.ram_dout, bus.if_data, bus.ls_rdata, bus.if_done, bus.ls_done);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.ram_a, bus.ram_wr, bus.ram_dout, bus.if_done, bus.ls_done} !== '0) begin
      errors++;
      $display("FAIL reset_idle got a=%h wr=%b do=%h ifd=%b lsd=%b exp all zero",
               bus.ram_a, bus.ram_wr, bus.ram_dout, bus.if_done, bus.ls_done);
    end
  endtask

  task automatic test_if_read();
    int first;
    int ndone;
    logic [31:0] got;
    preload(16'h1000, 8'h11);
    preload(16'h1001, 8'h22);
    preload(16'h1002, 8'h33);
    preload(16'h1003, 8'h44);
    @(negedge clk);
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h0000_1000;
    first = -1;
    ndone = 0;
    got   = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 0) begin
        checks++;
        if (bus.ram_a !== 32'h0000_1000) begin
          errors++;
          $display("FAIL if_first_addr got %h exp 00001000", bus.ram_a);
        end
      end
      if (bus.if_done === 1'b1) begin
        ndone++;
        if (first < 0) begin
          first = i;
          got   = bus.if_data;
          bus.if_req = 1'b0;
        end
      end
    end
    bus.if_req = 1'b0;
    checks++;
    if (first != 5) begin
      errors++;
      $display("FAIL if_latency got %0d exp 5", first);
    end
    checks++;
    if (ndone != 1) begin
      errors++;
      $display("FAIL if_done_width got %0d exp 1", ndone);
    end
    checks++;
    if (got !== 32'h4433_2211) begin
      errors++;
      $display("FAIL if_data got %h exp 44332211", got);
    end
  endtask

  task automatic test_loads();
    logic [31:0] d;
    int lat;
    preload(16'h0020, 8'h80);
    preload(16'h0040, 8'h34);
    preload(16'h0041, 8'hF2);
    do_load(32'h20, LEN_BYTE, 1'b1, d, lat);
    checks++;
    if (d !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_data got %h exp ffffff80", d); end
    checks++;
    if (lat != 2) begin errors++; $display("FAIL lb_latency got %0d exp 2", lat); end
    do_load(32'h20, LEN_BYTE, 1'b0, d, lat);
    checks++;
    if (d !== 32'h0000_0080) begin errors++; $display("FAIL lbu_data got %h exp 00000080", d); end
    do_load(32'h40, LEN_HALF, 1'b1, d, lat);
    checks++;
    if (d !== 32'hFFFF_F234) begin errors++; $display("FAIL lh_data got %h exp fffff234", d); end
    checks++;
    if (lat != 3) begin errors++; $display("FAIL lh_latency got %0d exp 3", lat); end
    do_load(32'h40, LEN_HALF, 1'b0, d, lat);
    checks++;
    if (d !== 32'h0000_F234) begin errors++; $display("FAIL lhu_data got %h exp 0000f234", d); end
  endtask

  task automatic test_store();
    logic [31:0] exp_a [4];
    logic [7:0]  exp_d [4];
    logic [31:0] d;
    int wr_n;
    int done_idx;
    int lat;
    exp_a = '{32'h30, 32'h31, 32'h32, 32'h33};
    exp_d = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    @(negedge clk);
    bus.ls_req   = 1'b1;
    bus.ls_wr    = 1'b1;
    bus.ls_len   = LEN_WORD;
    bus.ls_addr  = 32'h30;
    bus.ls_wdata = 32'hDEAD_BEEF;
    wr_n = 0;
    done_idx = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.ram_wr === 1'b1) begin
        if (wr_n < 4) begin
          checks++;
          if (bus.ram_a !== exp_a[wr_n] || bus.ram_dout !== exp_d[wr_n]) begin
            errors++;
            $display("FAIL sw_byte%0d got a=%h d=%h exp a=%h d=%h",
                     wr_n, bus.ram_a, bus.ram_dout, exp_a[wr_n], exp_d[wr_n]);
          end
        end
        wr_n++;
      end
      if (bus.ls_done === 1'b1 && done_idx < 0) begin
        done_idx = i;
        bus.ls_req = 1'b0;
      end
    end
    bus.ls_req = 1'b0;
    bus.ls_wr  = 1'b0;
    checks++;
    if (wr_n != 4) begin errors++; $display("FAIL sw_wr_cycles got %0d exp 4", wr_n); end
    checks++;
    if (done_idx != 4) begin errors++; $display("FAIL sw_done_edge got %0d exp 4", done_idx); end
    do_load(32'h30, LEN_WORD, 1'b0, d, lat);
    checks++;
    if (d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL sw_readback got %h exp deadbeef", d); end
    checks++;
    if (lat != 5) begin errors++; $display("FAIL lw_latency got %0d exp 5", lat); end
  endtask

  task automatic test_priority();
    int ls_idx;
    int if_idx;
    logic [31:0] ls_got;
    logic [31:0] if_got;
    @(negedge clk);
    bus.if_req    = 1'b1;
    bus.if_addr   = 32'h1000;
    bus.ls_req    = 1'b1;
    bus.ls_wr     = 1'b0;
    bus.ls_len    = LEN_BYTE;
    bus.ls_signed = 1'b0;
    bus.ls_addr   = 32'h20;
    ls_idx = -1;
    if_idx = -1;
    ls_got = '0;
    if_got = '0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (bus.ls_done === 1'b1 && ls_idx < 0) begin
        ls_idx = i;
        ls_got = bus.ls_rdata;
        bus.ls_req = 1'b0;
      end
      if (bus.if_done === 1'b1 && if_idx < 0) begin
        if_idx = i;
        if_got = bus.if_data;
        bus.if_req = 1'b0;
      end
    end
    bus.if_req = 1'b0;
    bus.ls_req = 1'b0;
    checks++;
    if (ls_idx != 2) begin errors++; $display("FAIL prio_ls_edge got %0d exp 2", ls_idx); end
    checks++;
    if (ls_got !== 32'h80) begin errors++; $display("FAIL prio_ls_data got %h exp 00000080", ls_got); end
    checks++;
    if (if_idx != 9) begin errors++; $display("FAIL prio_if_edge got %0d exp 9", if_idx); end
    checks++;
    if (if_got !== 32'h4433_2211) begin errors++; $display("FAIL prio_if_data got %h exp 44332211", if_got); end
  endtask

  task automatic test_rdy_freeze();
    int done_idx;
    logic [31:0] got;
    preload(16'hFFFE, 8'hA1);
    preload(16'hFFFF, 8'hB2);
    preload(16'h0000, 8'hC3);
    preload(16'h0001, 8'hD4);
    @(negedge clk);
    bus.if_req  = 1'b1;
    bus.if_addr = 32'hFFFF_FFFE;
    @(negedge clk);
    checks++;
    if (bus.ram_a !== 32'hFFFF_FFFE) begin errors++; $display("FAIL wrap_a0 got %h exp fffffffe", bus.ram_a); end
    @(negedge clk);
    checks++;
    if (bus.ram_a !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_a1 got %h exp ffffffff", bus.ram_a); end
    @(negedge clk);
    checks++;
    if (bus.ram_a !== 32'h0000_0000) begin errors++; $display("FAIL wrap_a2 got %h exp 00000000", bus.ram_a); end
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.ram_a !== 32'h0000_0000 || bus.if_done !== 1'b0) begin
        errors++;
        $display("FAIL freeze%0d got a=%h done=%b exp a=00000000 done=0", i, bus.ram_a, bus.if_done);
      end
    end
    rdy = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.ram_a !== 32'h0000_0001) begin errors++; $display("FAIL wrap_a3 got %h exp 00000001", bus.ram_a); end
    done_idx = -1;
    got = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.if_done === 1'b1 && done_idx < 0) begin
        done_idx = i;
        got = bus.if_data;
        bus.if_req = 1'b0;
      end
    end
    bus.if_req = 1'b0;
    checks++;
    if (done_idx != 1) begin errors++; $display("FAIL freeze_done_edge got %0d exp 1", done_idx); end
    checks++;
    if (got !== 32'hD4C3_B2A1) begin errors++; $display("FAIL freeze_data got %h exp d4c3b2a1", got); end
  endtask

  task automatic test_reset_mid_store();
    preload(16'h0050, 8'h00);
    preload(16'h0051, 8'h00);
    @(negedge clk);
    bus.ls_req   = 1'b1;
    bus.ls_wr    = 1'b1;
    bus.ls_len   = LEN_WORD;
    bus.ls_addr  = 32'h50;
    bus.ls_wdata = 32'h1122_3344;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.ram_wr !== 1'b1 || bus.ram_a !== 32'h51 || bus.ram_dout !== 8'h33) begin
      errors++;
      $display("FAIL rst_sw_progress got wr=%b a=%h d=%h exp wr=1 a=00000051 d=33",
               bus.ram_wr, bus.ram_a, bus.ram_dout);
    end
    rst_n = 1'b0;
    bus.ls_req = 1'b0;
    bus.ls_wr  = 1'b0;
    #1;
    checks++;
    if ({bus.ram_a, bus.ram_wr, bus.ram_dout, bus.if_data, bus.ls_rdata, bus.if_done, bus.ls_done} !== '0) begin
      errors++;
      $display("FAIL rst_mid_outputs got a=%h wr=%b do=%h if=%h ls=%h ifd=%b lsd=%b exp all zero",
               bus.ram_a, bus.ram_wr, bus.ram_dout, bus.if_data, bus.ls_rdata, bus.if_done, bus.ls_done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (mem[16'h0050] !== 8'h44 || mem[16'h0051] !== 8'h00) begin
      errors++;
      $display("FAIL rst_partial_store got %h %h exp 44 00", mem[16'h0050], mem[16'h0051]);
    end
    checks++;
    if (bus.ram_wr !== 1'b0) begin errors++; $display("FAIL rst_after_wr got %b exp 0", bus.ram_wr); end
  endtask

`ifdef MEM_CTRL_IF_ABORT_EN
  task automatic test_abort();
    int seen_if_done;
    int sb_idx;
    seen_if_done = 0;
    @(negedge clk);
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h1000;
    @(negedge clk);
    @(negedge clk);
    bus.if_abort = 1'b1;
    @(negedge clk);
    if (bus.if_done === 1'b1) seen_if_done++;
    bus.if_abort = 1'b0;
    bus.if_req   = 1'b0;
    bus.ls_req   = 1'b1;
    bus.ls_wr    = 1'b1;
    bus.ls_len   = LEN_BYTE;
    bus.ls_addr  = 32'h60;
    bus.ls_wdata = 32'h0000_005A;
    @(negedge clk);
    checks++;
    if (bus.ram_wr !== 1'b1 || bus.ram_a !== 32'h60 || bus.ram_dout !== 8'h5A) begin
      errors++;
      $display("FAIL abort_sb_accept got wr=%b a=%h d=%h exp wr=1 a=00000060 d=5a",
               bus.ram_wr, bus.ram_a, bus.ram_dout);
    end
    sb_idx = -1;
    for (int i = 1; i < 6; i++) begin
      @(negedge clk);
      if (bus.if_done === 1'b1) seen_if_done++;
      if (bus.ls_done === 1'b1 && sb_idx < 0) begin
        sb_idx = i;
        bus.ls_req = 1'b0;
      end
    end
    bus.ls_req = 1'b0;
    bus.ls_wr  = 1'b0;
    checks++;
    if (sb_idx != 1) begin errors++; $display("FAIL abort_sb_done got %0d exp 1", sb_idx); end
    bus.if_req   = 1'b1;
    bus.if_abort = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.if_done === 1'b1) seen_if_done++;
      checks++;
      if (bus.ram_a !== 32'h60) begin
        errors++;
        $display("FAIL abort_idle_block%0d got a=%h exp 00000060", i, bus.ram_a);
      end
    end
    bus.if_req   = 1'b0;
    bus.if_abort = 1'b0;
    checks++;
    if (seen_if_done != 0) begin errors++; $display("FAIL abort_no_done got %0d exp 0", seen_if_done); end
    checks++;
    if (bus.if_data !== 32'h0) begin errors++; $display("FAIL abort_if_data got %h exp 00000000", bus.if_data); end
  endtask
`endif

  initial begin
    rst_n         = 1'b0;
    rdy           = 1'b1;
    pl_en         = 1'b0;
    pl_a          = '0;
    pl_d          = '0;
    bus.if_req    = 1'b0;
    bus.if_addr   = '0;
`ifdef MEM_CTRL_IF_ABORT_EN
    bus.if_abort  = 1'b0;
`endif
    bus.ls_req    = 1'b0;
    bus.ls_wr     = 1'b0;
    bus.ls_len    = LEN_BYTE;
    bus.ls_signed = 1'b0;
    bus.ls_addr   = '0;
    bus.ls_wdata  = '0;

    test_reset();
    test_if_read();
    test_loads();
    test_store();
    test_priority();
    test_rdy_freeze();
    test_reset_mid_store();
`ifdef MEM_CTRL_IF_ABORT_EN
    test_abort();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
